// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - shared types, colour constants and pixel packing for the LCD timing controller
package lcd_timing_pkg;

    // Panel start-up sequencer states
    typedef enum logic {
        ST_PANEL_RST = 1'b0,
        ST_RUN       = 1'b1
    } lcd_state_e;

    // Bar colours, RGB888
    localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] C_BLACK   = 24'h000000;
    localparam logic [23:0] C_RED     = 24'hFF0000;
    localparam logic [23:0] C_GREEN   = 24'h00FF00;
    localparam logic [23:0] C_BLUE    = 24'h0000FF;
    localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] C_CYAN    = 24'h00FFFF;
    localparam logic [23:0] C_MAGENTA = 24'hFF00FF;

    // Colour of bar number idx, left to right
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = C_WHITE;
            3'd1:    c = C_BLACK;
            3'd2:    c = C_RED;
            3'd3:    c = C_GREEN;
            3'd4:    c = C_BLUE;
            3'd5:    c = C_YELLOW;
            3'd6:    c = C_CYAN;
            default: c = C_MAGENTA;
        endcase
        return c;
    endfunction

    // RGB888 -> panel format; 16 keeps the top bits of each channel (RGB565)
    function automatic logic [23:0] rgb_pack(input logic [23:0] c, input int data_w);
        if (data_w == 16)
            return {8'h00, c[23:19], c[15:10], c[7:3]};
        return c;
    endfunction

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// rtl/lcd_timing_ctrl_if.sv - pixel request/data link between timing controller and pixel source
//  data_req    : controller -> source, pixel wanted at (pixel_xpos, pixel_ypos)
//  pixel_xpos  : controller -> source, active-area column
//  pixel_ypos  : controller -> source, active-area row
//  pixel_data  : source -> controller, pixel returned REQ_LEAD cycles after data_req
interface lcd_timing_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int XW     = 9,
    parameter int YW     = 9
);
    logic              data_req;
    logic [XW-1:0]     pixel_xpos;
    logic [YW-1:0]     pixel_ypos;
    logic [DATA_W-1:0] pixel_data;

    modport master (
        output data_req,
        output pixel_xpos,
        output pixel_ypos,
        input  pixel_data
    );

    modport slave (
        input  data_req,
        input  pixel_xpos,
        input  pixel_ypos,
        output pixel_data
    );
endinterface

// File: rtl/lcd_colorbar_gen.sv
// rtl/lcd_colorbar_gen.sv - vertical colour-bar pattern source
//  clk, rst_n : pixel clock, asynchronous active-low reset
//  pix_en     : active-area flag of the counters (one cycle ahead of data_req)
//  pix_out    : bar pixel, aligned with the cycle pixel_data is expected
module lcd_colorbar_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = 480,
    parameter int NUM_BARS = 8,
    parameter int DATA_W   = 16,
    parameter int REQ_LEAD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    output logic [DATA_W-1:0] pix_out
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BW_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW_W-1:0] BAR_LAST = BW_W'(BAR_W - 1);

    logic [BW_W-1:0]   bar_cnt;
    logic [2:0]        bar_idx;
    logic [DATA_W-1:0] bar_pix;

    // Bar index advances every BAR_W pixels; blanking restarts the line at bar 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt <= '0;
            bar_idx <= '0;
            bar_pix <= '0;
        end else if (pix_en) begin
            bar_pix <= DATA_W'(rgb_pack(bar_colour(bar_idx), DATA_W));
            if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 1'b1;
            end
        end else begin
            bar_cnt <= '0;
            bar_idx <= '0;
            bar_pix <= '0;
        end
    end

    // Delay to the same point external pixel_data arrives
    if (REQ_LEAD == 0) begin : g_no_dly
        assign pix_out = bar_pix;
    end else begin : g_dly
        logic [DATA_W-1:0] dly [REQ_LEAD];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < REQ_LEAD; k++)
                    dly[k] <= '0;
            end else begin
                dly[0] <= bar_pix;
                for (int k = 1; k < REQ_LEAD; k++)
                    dly[k] <= dly[k-1];
            end
        end

        assign pix_out = dly[REQ_LEAD-1];
    end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// rtl/lcd_timing_ctrl.sv - parametrised RGB LCD timing controller
//  lcd_clk, sys_rst_n   : pixel clock, asynchronous active-low reset
//  pattern_en           : 1 = internal colour bars, 0 = external pixel_data (taken at frame boundary)
//  pix                  : data_req / pixel_xpos / pixel_ypos out, pixel_data in
//  frame_start          : pulse with the first lcd_de of each frame
//  lcd_hs/vs/de/rgb     : panel timing and pixel
//  lcd_bl, lcd_rst      : backlight enable, panel reset (active low)
module lcd_timing_ctrl
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC     = 41,
    parameter int H_BACK     = 2,
    parameter int H_ACTIVE   = 480,
    parameter int H_FRONT    = 2,
    parameter int V_SYNC     = 10,
    parameter int V_BACK     = 2,
    parameter int V_ACTIVE   = 272,
    parameter int V_FRONT    = 2,
    parameter int DATA_W     = 16,
    parameter int REQ_LEAD   = 1,
    parameter int NUM_BARS   = 8,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int RST_CYCLES = 16
) (
    input  logic               lcd_clk,
    input  logic               sys_rst_n,
    input  logic               pattern_en,
    lcd_timing_ctrl_if.master  pix,
    output logic               frame_start,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_de,
    output logic [DATA_W-1:0]  lcd_rgb,
    output logic               lcd_bl,
    output logic               lcd_rst
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int L       = REQ_LEAD;

    localparam logic [HW-1:0]   H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]   H_SYNC_C = HW'(H_SYNC);
    localparam logic [HW-1:0]   HA_FIRST = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0]   HA_LAST  = HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [VW-1:0]   V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]   V_SYNC_C = VW'(V_SYNC);
    localparam logic [VW-1:0]   VA_FIRST = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0]   VA_LAST  = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic            HS_ACT   = 1'(HS_POL);
    localparam logic            VS_ACT   = 1'(VS_POL);

    lcd_state_e        state, state_nxt;
    logic [RC_W-1:0]   rst_cnt;
    logic              run;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              hs_act, vs_act, de_act, fs_act;
    logic [L:0]        hs_pipe, vs_pipe, de_pipe, fs_pipe;
    logic [XW-1:0]     xpos_q;
    logic [YW-1:0]     ypos_q;
    logic              pattern_sel;
    logic [DATA_W-1:0] pat_pix;
    logic [DATA_W-1:0] src_pix;

    // ---------------- start-up sequencer ----------------
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= ST_PANEL_RST;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PANEL_RST: if (rst_cnt == RC_LAST) state_nxt = ST_RUN;
            default:      state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        run     = 1'b0;
        lcd_rst = 1'b0;
        lcd_bl  = 1'b0;
        if (state == ST_RUN) begin
            run     = 1'b1;
            lcd_rst = 1'b1;
            lcd_bl  = 1'b1;
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            rst_cnt <= '0;
        else if (state == ST_PANEL_RST)
            rst_cnt <= rst_cnt + 1'b1;
    end

    // ---------------- h/v counters ----------------
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Raw flags are gated by run so the panel sees idle syncs until start-up completes
    assign hs_act = run && (h_cnt < H_SYNC_C);
    assign vs_act = run && (v_cnt < V_SYNC_C);
    assign de_act = run && (h_cnt >= HA_FIRST) && (h_cnt <= HA_LAST)
                        && (v_cnt >= VA_FIRST) && (v_cnt <= VA_LAST);
    assign fs_act = de_act && (h_cnt == HA_FIRST) && (v_cnt == VA_FIRST);

    // Source choice only changes at the top-left corner so a frame is never mixed
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            pattern_sel <= 1'b0;
        else if (h_cnt == '0 && v_cnt == '0)
            pattern_sel <= pattern_en;
    end

    // ---------------- stage 0 + alignment pipe ----------------
    // Element 0 is the request stage; element L lines up with pixel_data
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
            de_pipe <= '0;
            fs_pipe <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
        end else begin
            hs_pipe[0] <= hs_act;
            vs_pipe[0] <= vs_act;
            de_pipe[0] <= de_act;
            fs_pipe[0] <= fs_act;
            for (int k = 1; k <= L; k++) begin
                hs_pipe[k] <= hs_pipe[k-1];
                vs_pipe[k] <= vs_pipe[k-1];
                de_pipe[k] <= de_pipe[k-1];
                fs_pipe[k] <= fs_pipe[k-1];
            end
            xpos_q <= de_act ? XW'(h_cnt - HA_FIRST) : '0;
            ypos_q <= de_act ? YW'(v_cnt - VA_FIRST) : '0;
        end
    end

    assign pix.data_req   = de_pipe[0];
    assign pix.pixel_xpos = xpos_q;
    assign pix.pixel_ypos = ypos_q;

    lcd_colorbar_gen #(
        .H_ACTIVE (H_ACTIVE),
        .NUM_BARS (NUM_BARS),
        .DATA_W   (DATA_W),
        .REQ_LEAD (REQ_LEAD)
    ) u_colorbar (
        .clk     (lcd_clk),
        .rst_n   (sys_rst_n),
        .pix_en  (de_act),
        .pix_out (pat_pix)
    );

    assign src_pix = pattern_sel ? pat_pix : pix.pixel_data;

    // ---------------- output stage ----------------
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcd_hs      <= ~HS_ACT;
            lcd_vs      <= ~VS_ACT;
            lcd_de      <= 1'b0;
            lcd_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            lcd_hs      <= hs_pipe[L] ? HS_ACT : ~HS_ACT;
            lcd_vs      <= vs_pipe[L] ? VS_ACT : ~VS_ACT;
            lcd_de      <= de_pipe[L];
            lcd_rgb     <= de_pipe[L] ? src_pix : '0;
            frame_start <= fs_pipe[L];
        end
    end

endmodule
